// File: rtl/keypad_scanner.sv
// keypad_scanner: row-scanning controller for a 4x3 matrix keypad.
// Drives one row at a time, samples the synchronized columns at the end of
// each row dwell, debounces whole-frame snapshots and emits single-key press
// events through a 1-entry valid/ready output buffer.
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while one key is held).
//
// Handshake: KEY_VALID/KEY_CODE form a valid/ready source. An event is
// transferred on any clock edge where KEY_VALID and KEY_READY are both high;
// KEY_CODE never changes while KEY_VALID is high unless that same edge is a
// transfer, and a new event that finds the buffer full and not being drained
// is dropped with a one-cycle OVERRUN pulse.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_SCANS   = 50
) (
    input  logic       CLK,
    input  logic       RST_N,
    output logic [3:0] ROW_DRIVE,
    input  logic [2:0] COL,
    output logic [3:0] KEY_CODE,
    output logic       KEY_VALID,
    input  logic       KEY_READY,
    output logic       KEY_HELD,
    output logic       OVERRUN
);

    localparam int             DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [3:0]     STABLE_MAX = 4'(DEBOUNCE_SCANS);

    logic [2:0]    col_meta;
    logic [2:0]    col_sync;
    logic [DW-1:0] dwell;
    logic [1:0]    row;
    // Rows 0..2 are stored; row 3 is taken straight from col_sync at frame end.
    logic [8:0]    work;
    logic [11:0]   prev_snap;
    logic [11:0]   deb_state;
    logic [3:0]    stable;

    logic          last_dwell;
    logic          frame_end;
    logic [11:0]   frame_snap;
    logic [3:0]    stable_nxt;
    logic          accept;
    logic [3:0]    snap_ones;
    logic [3:0]    snap_idx;
    logic          single_key;
    logic          new_press;
    logic          rpt_hit;
    logic          event_fire;

    assign last_dwell = (dwell == DWELL_LAST);
    assign frame_end  = last_dwell && (row == 2'd3);
    assign frame_snap = {col_sync, work};

    // Population count and index of the highest set bit of the frame snapshot.
    always_comb begin
        snap_ones = 4'd0;
        snap_idx  = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (frame_snap[i]) begin
                snap_ones = snap_ones + 4'd1;
                snap_idx  = 4'(i);
            end
        end
    end

    // Next stable count: saturating increment on a repeated frame, else clear.
    always_comb begin
        stable_nxt = 4'd0;
        if (frame_snap == prev_snap) begin
            stable_nxt = (stable == STABLE_MAX) ? stable : stable + 4'd1;
        end
    end

    assign accept     = frame_end && (stable_nxt == STABLE_MAX);
    assign single_key = (snap_ones == 4'd1);
    assign new_press  = single_key && ((frame_snap & deb_state) == 12'd0);

`ifdef KEYPAD_REPEAT_EN
    logic [7:0] rpt_cnt;

    // A repeat is due on the REPEAT_SCANS-th accepting frame with the same single key.
    assign rpt_hit = accept && single_key && (frame_snap == deb_state) &&
                     (rpt_cnt == 8'(REPEAT_SCANS - 1));

    // Repeat counter: counts accepting frames of an unchanged single-key state.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rpt_cnt <= 8'd0;
        end else if (accept) begin
            if ((frame_snap != deb_state) || !single_key || rpt_hit) begin
                rpt_cnt <= 8'd0;
            end else begin
                rpt_cnt <= rpt_cnt + 8'd1;
            end
        end
    end
`else
    assign rpt_hit = 1'b0;
`endif

    assign event_fire = accept && single_key && (new_press || rpt_hit);

    // Two-flop synchronizer for the asynchronous column lines.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            col_meta <= 3'd0;
            col_sync <= 3'd0;
        end else begin
            col_meta <= COL;
            col_sync <= col_meta;
        end
    end

    // Dwell counter and row pointer; the row drive rotates when the dwell wraps.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            dwell     <= '0;
            row       <= 2'd0;
            ROW_DRIVE <= 4'b0001;
        end else if (last_dwell) begin
            dwell     <= '0;
            row       <= row + 2'd1;
            ROW_DRIVE <= {ROW_DRIVE[2:0], ROW_DRIVE[3]};
        end else begin
            dwell <= dwell + DW'(1);
        end
    end

    // Capture the synchronized columns on the last dwell cycle of rows 0..2.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            work <= 9'd0;
        end else if (last_dwell) begin
            case (row)
                2'd0:    work[2:0] <= col_sync;
                2'd1:    work[5:3] <= col_sync;
                2'd2:    work[8:6] <= col_sync;
                default: ;
            endcase
        end
    end

    // Frame-end debounce: track stability and load the debounced state on accept.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            stable    <= 4'd0;
            prev_snap <= 12'd0;
            deb_state <= 12'd0;
            KEY_HELD  <= 1'b0;
        end else if (frame_end) begin
            stable    <= stable_nxt;
            prev_snap <= frame_snap;
            if (accept) begin
                deb_state <= frame_snap;
                KEY_HELD  <= (frame_snap != 12'd0);
            end
        end
    end

    // One-entry output buffer with overrun detection.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            KEY_CODE  <= 4'd0;
            KEY_VALID <= 1'b0;
            OVERRUN   <= 1'b0;
        end else begin
            OVERRUN <= 1'b0;
            if (event_fire) begin
                if (KEY_VALID && !KEY_READY) begin
                    OVERRUN <= 1'b1;
                end else begin
                    KEY_CODE  <= snap_idx;
                    KEY_VALID <= 1'b1;
                end
            end else if (KEY_VALID && KEY_READY) begin
                KEY_VALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with a keypad matrix
// model, an expected-code queue and a monitor that pops on each handshake.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int RPT      = 3;

  logic       CLK;
  logic       RST_N;
  logic [3:0] ROW_DRIVE;
  logic [2:0] COL;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       KEY_READY;
  logic       KEY_HELD;
  logic       OVERRUN;

  logic [11:0] keys;
  logic        use_force;
  logic [2:0]  force_col;
  logic [2:0]  matrix_col;

  logic [3:0] exp_q[$];
  int checks;
  int failures;
  int ovr_cnt;

  keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS(RPT)
  ) dut (
    .CLK(CLK),
    .RST_N(RST_N),
    .ROW_DRIVE(ROW_DRIVE),
    .COL(COL),
    .KEY_CODE(KEY_CODE),
    .KEY_VALID(KEY_VALID),
    .KEY_READY(KEY_READY),
    .KEY_HELD(KEY_HELD),
    .OVERRUN(OVERRUN)
  );

  // clock / reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // keypad matrix: a pressed key connects its row line to its column line
  always_comb begin
    matrix_col = 3'b000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (ROW_DRIVE[r] && keys[r*3+c]) matrix_col[c] = 1'b1;
      end
    end
  end
  assign COL = use_force ? force_col : matrix_col;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // scoreboard monitor: compare each accepted event with the queue head
  always @(negedge CLK) begin
    if (RST_N && OVERRUN) ovr_cnt++;
    if (RST_N && KEY_VALID && KEY_READY) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_event actual=%0d expected=none", KEY_CODE);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (KEY_CODE != e) begin
          failures++;
          $display("FAIL event_code actual=%0d expected=%0d", KEY_CODE, e);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic wait_held(input logic val, input string name);
    int n;
    n = 0;
    while (KEY_HELD !== val && n < 160) begin
      tick(1);
      n++;
    end
    check(name, int'(KEY_HELD), int'(val));
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    while (KEY_VALID !== 1'b1 && n < 160) begin
      tick(1);
      n++;
    end
    check(name, int'(KEY_VALID), 1);
  endtask

  task automatic wait_qsize(input int target, input string name);
    int n;
    n = 0;
    while (exp_q.size() > target && n < 160) begin
      tick(1);
      n++;
    end
    check(name, exp_q.size(), target);
  endtask

  // driver
  initial begin
    checks = 0;
    failures = 0;
    ovr_cnt = 0;
    RST_N = 1'b0;
    KEY_READY = 1'b1;
    keys = 12'd0;
    use_force = 1'b0;
    force_col = 3'b000;

    // reset values
    tick(3);
    check("rst_row_drive", int'(ROW_DRIVE), 1);
    check("rst_key_code", int'(KEY_CODE), 0);
    check("rst_key_valid", int'(KEY_VALID), 0);
    check("rst_key_held", int'(KEY_HELD), 0);
    check("rst_overrun", int'(OVERRUN), 0);

    // idle scan: row drive sequence, 4 cycles per row, wraps every 16
    @(posedge CLK);
    #1 RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      check("row_seq", int'(ROW_DRIVE), 1 << ((i / 4) % 4));
    end
    tick(1);
    check("idle_valid", int'(KEY_VALID), 0);

    // key 7 (row 2, col 1) held with ready high
    exp_q.push_back(4'd7);
    keys[7] = 1'b1;
    wait_qsize(0, "key7_event");
    check("key7_valid_one_cycle", int'(KEY_VALID), 0);
    check("key7_held", int'(KEY_HELD), 1);
    keys = 12'd0;
    wait_held(1'b0, "key7_release");

    // column chatter for 5 frames, then key 0 held
    use_force = 1'b1;
    force_col = 3'b111;
    repeat (8) begin
      tick(10);
      force_col = ~force_col;
    end
    use_force = 1'b0;
    keys[0] = 1'b1;
    exp_q.push_back(4'd0);
    wait_qsize(0, "key0_event");
    keys = 12'd0;
    wait_held(1'b0, "key0_release");

    // keys 4 and 5 together: ghosting, no event but held
    keys[4] = 1'b1;
    keys[5] = 1'b1;
    wait_held(1'b1, "ghost_held");
    tick(48);
    check("ghost_no_valid", int'(KEY_VALID), 0);
    keys = 12'd0;
    wait_held(1'b0, "ghost_release");

    // ready low: key 3 buffered, key 9 dropped with one overrun
    KEY_READY = 1'b0;
    exp_q.push_back(4'd3);
    keys[3] = 1'b1;
    wait_valid("key3_valid");
    keys = 12'd0;
    wait_held(1'b0, "key3_release");
    keys[9] = 1'b1;
    wait_held(1'b1, "key9_held");
    keys = 12'd0;
    wait_held(1'b0, "key9_release");
    check("overrun_count", ovr_cnt, 1);
    check("code_kept", int'(KEY_CODE), 3);
    check("valid_kept", int'(KEY_VALID), 1);
    KEY_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    check("valid_falls", int'(KEY_VALID), 0);
    check("key3_drained", exp_q.size(), 0);

    // key 11 held: one event, plus repeats every 3 frames when enabled
    tick(1);
    exp_q.push_back(4'd11);
`ifdef KEYPAD_REPEAT_EN
    exp_q.push_back(4'd11);
    exp_q.push_back(4'd11);
`endif
    keys[11] = 1'b1;
    wait_qsize(exp_q.size() - 1, "key11_first");
    tick(135);
    keys = 12'd0;
    wait_held(1'b0, "key11_release");
    check("key11_all_events", exp_q.size(), 0);
    check("key11_no_overrun", ovr_cnt, 1);

    // reset mid-frame with a pending event
    KEY_READY = 1'b0;
    keys[1] = 1'b1;
    wait_valid("key1_valid");
    keys = 12'd0;
    tick(5);
    #2 RST_N = 1'b0;
    #1;
    check("arst_row_drive", int'(ROW_DRIVE), 1);
    check("arst_key_code", int'(KEY_CODE), 0);
    check("arst_key_valid", int'(KEY_VALID), 0);
    check("arst_key_held", int'(KEY_HELD), 0);
    check("arst_overrun", int'(OVERRUN), 0);
    tick(2);
    KEY_READY = 1'b1;
    RST_N = 1'b1;
    tick(64);
    check("post_reset_idle", int'(KEY_VALID), 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
